// File: rtl/sim_run_ctrl.sv
// rtl/sim_run_ctrl.sv - run controller: DUT reset/init sequencing, cycle/commit counting, exit decode
// Finish is sticky until the asynchronous controller reset is asserted again.
module sim_run_ctrl #(
  parameter int NUM_CORES    = 1,
  parameter int CYCLE_W      = 64,
  parameter int CODE_W       = 8,
  parameter int RESET_CYCLES = 50,
  parameter int WDOG_CYCLES  = 5000,
  parameter int CORE_W       = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                        clock,
  input  logic                        reset,
  output logic                        dut_reset,
  output logic                        init_req,
  input  logic                        init_ack,
  input  logic [CYCLE_W-1:0]          max_cycles,
  input  logic [NUM_CORES-1:0]        commit_valid,
  input  logic [NUM_CORES-1:0]        trap_valid,
  input  logic [NUM_CORES*CODE_W-1:0] trap_code,
  input  logic                        diff_err,
  output logic                        finish,
  output logic [2:0]                  exit_cause,
  output logic [CORE_W-1:0]           exit_core,
  output logic [CODE_W-1:0]           exit_code,
  output logic [CYCLE_W-1:0]          cycle_cnt,
  output logic [CYCLE_W-1:0]          instr_cnt
);

  localparam int HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam int WDOG_W = (WDOG_CYCLES > 0) ? $clog2(WDOG_CYCLES + 1) : 1;

  localparam logic [2:0] CAUSE_NONE  = 3'd0;
  localparam logic [2:0] CAUSE_GOOD  = 3'd1;
  localparam logic [2:0] CAUSE_BAD   = 3'd2;
  localparam logic [2:0] CAUSE_DIFF  = 3'd3;
  localparam logic [2:0] CAUSE_LIMIT = 3'd4;
  localparam logic [2:0] CAUSE_WDOG  = 3'd5;

  typedef enum logic [1:0] {S_HOLD, S_INIT, S_RUN, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [WDOG_W-1:0]   wdog_q, wdog_d;
  logic [CYCLE_W-1:0]  limit_q, limit_d;
  logic [CYCLE_W-1:0]  cycle_cnt_q, cycle_cnt_d;
  logic [CYCLE_W-1:0]  instr_cnt_q, instr_cnt_d;
  logic                dut_reset_q, dut_reset_d;
  logic                init_req_q, init_req_d;
  logic                finish_q, finish_d;
  logic [2:0]          exit_cause_q, exit_cause_d;
  logic [CORE_W-1:0]   exit_core_q, exit_core_d;
  logic [CODE_W-1:0]   exit_code_q, exit_code_d;

  logic [CYCLE_W-1:0]  commit_cnt;
  logic [CORE_W-1:0]   trap_sel;
  logic [CODE_W-1:0]   trap_code_sel;
  logic [2:0]          cause;

  always_comb begin
    commit_cnt    = '0;
    trap_sel      = '0;
    trap_code_sel = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      commit_cnt = commit_cnt + CYCLE_W'(commit_valid[i]);
    end
    // Descending scan so the lowest-index trapping core is the last writer.
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (trap_valid[i]) begin
        trap_sel      = CORE_W'(i);
        trap_code_sel = trap_code[i*CODE_W +: CODE_W];
      end
    end

    state_d      = state_q;
    hold_cnt_d   = hold_cnt_q;
    wdog_d       = wdog_q;
    limit_d      = limit_q;
    cycle_cnt_d  = cycle_cnt_q;
    instr_cnt_d  = instr_cnt_q;
    dut_reset_d  = dut_reset_q;
    init_req_d   = init_req_q;
    finish_d     = finish_q;
    exit_cause_d = exit_cause_q;
    exit_core_d  = exit_core_q;
    exit_code_d  = exit_code_q;
    cause        = CAUSE_NONE;

    case (state_q)
      S_HOLD: begin
        if (hold_cnt_q == HOLD_W'(RESET_CYCLES - 1)) begin
          state_d     = S_INIT;
          dut_reset_d = 1'b0;
          init_req_d  = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      S_INIT: begin
        if (init_ack) begin
          init_req_d = 1'b0;
          limit_d    = max_cycles;
          state_d    = S_RUN;
        end
      end
      S_RUN: begin
        cycle_cnt_d = cycle_cnt_q + CYCLE_W'(1);
        instr_cnt_d = instr_cnt_q + commit_cnt;
        wdog_d      = (|commit_valid) ? '0 : wdog_q + WDOG_W'(1);

        if (diff_err) begin
          cause = CAUSE_DIFF;
        end else if (|trap_valid) begin
          cause       = (trap_code_sel == '0) ? CAUSE_GOOD : CAUSE_BAD;
          exit_core_d = trap_sel;
          exit_code_d = trap_code_sel;
        end else if ((WDOG_CYCLES != 0) && (wdog_d == WDOG_W'(WDOG_CYCLES))) begin
          cause = CAUSE_WDOG;
        end else if ((limit_q != '0) && (cycle_cnt_d == limit_q)) begin
          cause = CAUSE_LIMIT;
        end

        if (cause != CAUSE_NONE) begin
          state_d      = S_DONE;
          finish_d     = 1'b1;
          exit_cause_d = cause;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= S_HOLD;
      hold_cnt_q   <= '0;
      wdog_q       <= '0;
      limit_q      <= '0;
      cycle_cnt_q  <= '0;
      instr_cnt_q  <= '0;
      dut_reset_q  <= 1'b1;
      init_req_q   <= 1'b0;
      finish_q     <= 1'b0;
      exit_cause_q <= CAUSE_NONE;
      exit_core_q  <= '0;
      exit_code_q  <= '0;
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      wdog_q       <= wdog_d;
      limit_q      <= limit_d;
      cycle_cnt_q  <= cycle_cnt_d;
      instr_cnt_q  <= instr_cnt_d;
      dut_reset_q  <= dut_reset_d;
      init_req_q   <= init_req_d;
      finish_q     <= finish_d;
      exit_cause_q <= exit_cause_d;
      exit_core_q  <= exit_core_d;
      exit_code_q  <= exit_code_d;
    end
  end

  assign dut_reset  = dut_reset_q;
  assign init_req   = init_req_q;
  assign finish     = finish_q;
  assign exit_cause = exit_cause_q;
  assign exit_core  = exit_core_q;
  assign exit_code  = exit_code_q;
  assign cycle_cnt  = cycle_cnt_q;
  assign instr_cnt  = instr_cnt_q;

endmodule

// File: tb/tb_sim_run_ctrl.sv
// tb/tb_sim_run_ctrl.sv - directed self-checking bench for sim_run_ctrl
// Instance a: 4 cores, 16-bit counters, watchdog 16. Instance b: 1 core, 8-bit counters, no watchdog.
module tb_sim_run_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        a_rstn, a_dut_reset, a_init_req, a_ack, a_diff, a_finish;
  logic [15:0] a_max, a_cyc, a_instr;
  logic [3:0]  a_commit, a_trap;
  logic [31:0] a_code;
  logic [2:0]  a_cause;
  logic [1:0]  a_core;
  logic [7:0]  a_xcode;

  logic        b_rstn, b_dut_reset, b_init_req, b_ack, b_diff, b_finish;
  logic [7:0]  b_max, b_cyc, b_instr;
  logic [0:0]  b_commit, b_trap, b_core;
  logic [7:0]  b_code;
  logic [2:0]  b_cause;
  logic [7:0]  b_xcode;

  sim_run_ctrl #(.NUM_CORES(4), .CYCLE_W(16), .CODE_W(8), .RESET_CYCLES(4), .WDOG_CYCLES(16)) u_a (
    .clock(clk), .reset(a_rstn), .dut_reset(a_dut_reset), .init_req(a_init_req), .init_ack(a_ack),
    .max_cycles(a_max), .commit_valid(a_commit), .trap_valid(a_trap), .trap_code(a_code),
    .diff_err(a_diff), .finish(a_finish), .exit_cause(a_cause), .exit_core(a_core),
    .exit_code(a_xcode), .cycle_cnt(a_cyc), .instr_cnt(a_instr)
  );

  sim_run_ctrl #(.NUM_CORES(1), .CYCLE_W(8), .CODE_W(8), .RESET_CYCLES(4), .WDOG_CYCLES(0)) u_b (
    .clock(clk), .reset(b_rstn), .dut_reset(b_dut_reset), .init_req(b_init_req), .init_ack(b_ack),
    .max_cycles(b_max), .commit_valid(b_commit), .trap_valid(b_trap), .trap_code(b_code),
    .diff_err(b_diff), .finish(b_finish), .exit_cause(b_cause), .exit_core(b_core),
    .exit_code(b_xcode), .cycle_cnt(b_cyc), .instr_cnt(b_instr)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_start(input logic [15:0] lim);
    a_rstn = 1'b0; a_commit = '0; a_trap = '0; a_diff = 1'b0; a_ack = 1'b0; a_max = '0;
    step();
    a_rstn = 1'b1;
    for (int i = 0; i < 20 && !a_init_req; i++) step();
    checks++; if (a_init_req !== 1'b1) begin errors++; $display("FAIL a_start_init_req got %0b exp 1", a_init_req); end
    a_max = lim; a_ack = 1'b1;
    step();
    a_ack = 1'b0;
    a_max = 16'd2;
  endtask

  task automatic b_start(input logic [7:0] lim);
    b_rstn = 1'b0; b_commit = '0; b_trap = '0; b_diff = 1'b0; b_ack = 1'b0; b_max = '0;
    step();
    b_rstn = 1'b1;
    for (int i = 0; i < 20 && !b_init_req; i++) step();
    checks++; if (b_init_req !== 1'b1) begin errors++; $display("FAIL b_start_init_req got %0b exp 1", b_init_req); end
    b_max = lim; b_ack = 1'b1;
    step();
    b_ack = 1'b0;
    b_max = 8'd0;
  endtask

  task automatic test_reset();
    int n;
    int m;
    b_rstn = 1'b0;
    #1;
    checks++; if (b_dut_reset !== 1'b1) begin errors++; $display("FAIL reset_dut_reset got %0b exp 1", b_dut_reset); end
    checks++; if (b_init_req !== 1'b0) begin errors++; $display("FAIL reset_init_req got %0b exp 0", b_init_req); end
    checks++; if (b_finish !== 1'b0 || b_cause !== 3'd0) begin errors++; $display("FAIL reset_finish got %0b/%0d exp 0/0", b_finish, b_cause); end
    checks++; if (b_cyc !== 8'd0 || b_instr !== 8'd0) begin errors++; $display("FAIL reset_counters got %0d/%0d exp 0/0", b_cyc, b_instr); end
    step();
    b_rstn = 1'b1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      n++;
      if (!b_dut_reset) break;
    end
    checks++; if (n != 4) begin errors++; $display("FAIL reset_hold_edges got %0d exp 4", n); end
    checks++; if (b_init_req !== 1'b1) begin errors++; $display("FAIL reset_init_req_rise got %0b exp 1", b_init_req); end
    m = 1;
    repeat (2) begin
      step();
      if (b_init_req) m++;
    end
    b_max = 8'd100; b_ack = 1'b1;
    step();
    b_ack = 1'b0; b_max = 8'd0; b_commit = 1'b1;
    checks++; if (m != 3 || b_init_req !== 1'b0) begin errors++; $display("FAIL init_req_width got %0d/%0b exp 3/0", m, b_init_req); end
    checks++; if (b_cyc !== 8'd0) begin errors++; $display("FAIL run_entry_cycle got %0d exp 0", b_cyc); end
    step();
    checks++; if (b_cyc !== 8'd1 || b_instr !== 8'd1) begin errors++; $display("FAIL first_run_edge got %0d/%0d exp 1/1", b_cyc, b_instr); end
  endtask

  task automatic test_cycle_limit();
    int fin;
    fin = 0;
    for (int i = 2; i <= 200; i++) begin
      step();
      if (b_finish) begin fin = i; break; end
    end
    checks++; if (fin != 100) begin errors++; $display("FAIL limit_finish_edge got %0d exp 100", fin); end
    checks++; if (b_cause !== 3'd4) begin errors++; $display("FAIL limit_cause got %0d exp 4", b_cause); end
    checks++; if (b_cyc !== 8'd100 || b_instr !== 8'd100) begin errors++; $display("FAIL limit_counters got %0d/%0d exp 100/100", b_cyc, b_instr); end
    checks++; if (b_core !== 1'b0 || b_xcode !== 8'd0) begin errors++; $display("FAIL limit_exit_fields got %0d/%0h exp 0/0", b_core, b_xcode); end
  endtask

  task automatic test_unlimited_wrap();
    int seen;
    b_start(8'd0);
    b_commit = 1'b1;
    seen = 0;
    for (int i = 0; i < 10000; i++) begin
      if (i == 300) b_commit = 1'b0;
      step();
      if (b_finish !== 1'b0) seen = 1;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL unlimited_no_finish got %0d exp 0", seen); end
    checks++; if (b_instr !== 8'd44) begin errors++; $display("FAIL instr_wrap got %0d exp 44", b_instr); end
    checks++; if (b_cyc !== 8'd16) begin errors++; $display("FAIL cycle_wrap got %0d exp 16", b_cyc); end
    checks++; if (b_cause !== 3'd0) begin errors++; $display("FAIL unlimited_cause got %0d exp 0", b_cause); end
  endtask

  task automatic test_limit_one();
    a_start(16'd1);
    a_commit = 4'b0001;
    step();
    checks++; if (a_finish !== 1'b1 || a_cause !== 3'd4) begin errors++; $display("FAIL limit1_finish got %0b/%0d exp 1/4", a_finish, a_cause); end
    checks++; if (a_cyc !== 16'd1 || a_instr !== 16'd1) begin errors++; $display("FAIL limit1_counters got %0d/%0d exp 1/1", a_cyc, a_instr); end
  endtask

  task automatic test_trap_priority();
    a_start(16'd0);
    a_code = 32'h0577_0011;
    a_commit = 4'b1011;
    repeat (10) step();
    checks++; if (a_finish !== 1'b0 || a_instr !== 16'd30 || a_cyc !== 16'd10) begin errors++; $display("FAIL trap_pre got %0b/%0d/%0d exp 0/30/10", a_finish, a_instr, a_cyc); end
    a_trap = 4'b1010;
    step();
    a_trap = '0;
    checks++; if (a_finish !== 1'b1 || a_cause !== 3'd1) begin errors++; $display("FAIL trap_good_cause got %0b/%0d exp 1/1", a_finish, a_cause); end
    checks++; if (a_core !== 2'd1 || a_xcode !== 8'h00) begin errors++; $display("FAIL trap_lowest_core got %0d/%0h exp 1/00", a_core, a_xcode); end
    checks++; if (a_instr !== 16'd33 || a_cyc !== 16'd11) begin errors++; $display("FAIL trap_counters got %0d/%0d exp 33/11", a_instr, a_cyc); end
  endtask

  task automatic test_bad_trap();
    a_start(16'd0);
    a_code = 32'h0577_0011;
    a_trap = 4'b0100;
    step();
    a_trap = '0;
    checks++; if (a_cause !== 3'd2 || a_core !== 2'd2 || a_xcode !== 8'h77) begin errors++; $display("FAIL bad_trap got %0d/%0d/%0h exp 2/2/77", a_cause, a_core, a_xcode); end
    checks++; if (a_cyc !== 16'd1 || a_instr !== 16'd0) begin errors++; $display("FAIL bad_trap_counters got %0d/%0d exp 1/0", a_cyc, a_instr); end
  endtask

  task automatic test_diff_err();
    int bad;
    a_start(16'd0);
    a_diff = 1'b1; a_trap = 4'b0001; a_code = 32'h0000_0022; a_commit = 4'b0001;
    step();
    checks++; if (a_finish !== 1'b1 || a_cause !== 3'd3) begin errors++; $display("FAIL diff_cause got %0b/%0d exp 1/3", a_finish, a_cause); end
    checks++; if (a_core !== 2'd0 || a_xcode !== 8'h00) begin errors++; $display("FAIL diff_exit_fields got %0d/%0h exp 0/00", a_core, a_xcode); end
    a_diff = 1'b0; a_commit = 4'b1111;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      a_trap = 4'(i);
      step();
      if (a_finish !== 1'b1 || a_cyc !== 16'd1 || a_instr !== 16'd1 || a_cause !== 3'd3) bad++;
    end
    a_trap = '0;
    checks++; if (bad != 0) begin errors++; $display("FAIL done_frozen got %0d bad cycles exp 0", bad); end
  endtask

  task automatic test_watchdog();
    int fin;
    a_start(16'd0);
    a_commit = '0;
    repeat (4) step();
    a_commit = 4'b0001;
    step();
    a_commit = '0;
    fin = 0;
    for (int e = 6; e <= 60; e++) begin
      step();
      if (a_finish) begin fin = e; break; end
    end
    checks++; if (fin != 21) begin errors++; $display("FAIL wdog_finish_edge got %0d exp 21", fin); end
    checks++; if (a_cause !== 3'd5 || a_cyc !== 16'd21 || a_instr !== 16'd1) begin errors++; $display("FAIL wdog_state got %0d/%0d/%0d exp 5/21/1", a_cause, a_cyc, a_instr); end
  endtask

  task automatic test_reset_abort();
    a_rstn = 1'b0;
    #1;
    checks++; if (a_finish !== 1'b0 || a_cause !== 3'd0 || a_core !== 2'd0) begin errors++; $display("FAIL done_abort got %0b/%0d/%0d exp 0/0/0", a_finish, a_cause, a_core); end
    a_start(16'd3);
    a_commit = 4'b1111;
    step();
    a_rstn = 1'b0;
    #1;
    checks++; if (a_dut_reset !== 1'b1 || a_init_req !== 1'b0 || a_finish !== 1'b0) begin errors++; $display("FAIL run_abort_ctrl got %0b/%0b/%0b exp 1/0/0", a_dut_reset, a_init_req, a_finish); end
    checks++; if (a_cyc !== 16'd0 || a_instr !== 16'd0) begin errors++; $display("FAIL run_abort_counters got %0d/%0d exp 0/0", a_cyc, a_instr); end
    step();
    a_rstn = 1'b1;
    for (int i = 0; i < 20 && !a_init_req; i++) step();
    step();
    a_rstn = 1'b0;
    #1;
    checks++; if (a_init_req !== 1'b0 || a_dut_reset !== 1'b1) begin errors++; $display("FAIL init_abort got %0b/%0b exp 0/1", a_init_req, a_dut_reset); end
    step();
    a_rstn = 1'b1;
    for (int i = 0; i < 20 && !a_init_req; i++) step();
    checks++; if (a_init_req !== 1'b1) begin errors++; $display("FAIL restart_init_req got %0b exp 1", a_init_req); end
    a_max = 16'd0; a_ack = 1'b1;
    step();
    a_ack = 1'b0; a_commit = 4'b1111;
    repeat (10) step();
    checks++; if (a_finish !== 1'b0 || a_cyc !== 16'd10 || a_instr !== 16'd40) begin errors++; $display("FAIL stale_limit got %0b/%0d/%0d exp 0/10/40", a_finish, a_cyc, a_instr); end
  endtask

  initial begin
    a_rstn = 1'b0; a_ack = 1'b0; a_max = '0; a_commit = '0; a_trap = '0; a_code = '0; a_diff = 1'b0;
    b_rstn = 1'b0; b_ack = 1'b0; b_max = '0; b_commit = '0; b_trap = '0; b_code = '0; b_diff = 1'b0;
    step();
    test_reset();
    test_cycle_limit();
    test_unlimited_wrap();
    test_limit_one();
    test_trap_priority();
    test_bad_trap();
    test_diff_err();
    test_watchdog();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sim_run_ctrl.md
# sim_run_ctrl

Synthesizable run controller for the simulation top, parametrised over core count. It sequences DUT reset and the one-time init handshake, then counts cycles and per-cycle commits across `NUM_CORES` commit channels. It terminates the run on the first of: good/bad trap, difftest error, cycle limit, or commit-watchdog timeout. It drives a sticky `finish` with a decoded exit cause, for the bench or an FPGA host to poll.

## Interface
Parameters:
- `NUM_CORES`, 1, number of commit/trap channels (1..8)
- `CYCLE_W`, 64, width of cycle and instruction counters and cycle limit
- `CODE_W`, 8, width of each trap code
- `RESET_CYCLES`, 50, cycles `dut_reset` is held after controller reset release (≥1)
- `WDOG_CYCLES`, 5000, consecutive commit-free RUN cycles before timeout; 0 disables
- `CORE_W`, max(1, clog2(NUM_CORES)), derived; width of `exit_core`

Ports:
- `clock`, in, 1, single clock domain; all logic on rising edge
- `reset`, in, 1, **asynchronous, active-low** controller reset
- `dut_reset`, out, 1, active-high reset to the DUT
- `init_req`, out, 1, requests host-side init
- `init_ack`, in, 1, init complete; single-cycle or level
- `max_cycles`, in, CYCLE_W, RUN cycle limit; 0 = unlimited; sampled on INIT→RUN
- `commit_valid`, in, NUM_CORES, one bit per core per committed instruction
- `trap_valid`, in, NUM_CORES, core i executed its halt/trap instruction
- `trap_code`, in, NUM_CORES*CODE_W, core i code in bits [i*CODE_W +: CODE_W]
- `diff_err`, in, 1, difftest mismatch
- `finish`, out, 1, run ended; sticky until reset
- `exit_cause`, out, 3, 0 none, 1 good trap, 2 bad trap, 3 diff error, 4 cycle limit, 5 watchdog
- `exit_core`, out, CORE_W, core index for causes 1/2, else 0
- `exit_code`, out, CODE_W, trap code for causes 1/2, else 0
- `cycle_cnt`, out, CYCLE_W, RUN cycles elapsed
- `instr_cnt`, out, CYCLE_W, total commits across all cores

## Operation
- FSM: HOLD → INIT → RUN → DONE. On async reset (`reset`=0): state HOLD, `dut_reset`=1, all other outputs 0, all counters 0.
- HOLD: hold counter counts clock edges after `reset` rises. After `RESET_CYCLES` edges, go to INIT and set `dut_reset`=0.
- INIT: `init_req`=1. When `init_ack`=1 is sampled, drop `init_req`, latch `max_cycles`, and go to RUN.
- RUN: per cycle:
  - `cycle_cnt` += 1
  - `instr_cnt` += popcount(`commit_valid`); wraps mod 2^CYCLE_W
  - watchdog counter clears on any commit, else increments
- Termination events in RUN, evaluated together on the same edge, highest priority first:
  1. `diff_err` → cause 3.
  2. Any `trap_valid`: the lowest-index core wins. Code 0 → cause 1, nonzero → cause 2. Latch core index and code.
  3. Watchdog: `WDOG_CYCLES`≠0 and the counter's next value = `WDOG_CYCLES` → cause 5.
  4. Cycle limit: latched limit ≠0 and `cycle_cnt`+1 = limit → cause 4.
- On any event: go to DONE and latch the cause. Counters include that final cycle's increment.
- DONE: `finish`=1, counters and exit fields frozen. All inputs ignored until reset.
- `commit_valid`, `trap_valid` and `diff_err` are ignored outside RUN. `init_ack` is ignored outside INIT.
- Reset asserted in any state aborts immediately to HOLD with reset values. Latched limit and latched exit fields clear.

## Timing
- `dut_reset` falls exactly `RESET_CYCLES` rising edges after `reset` deasserts. `init_req` rises on the same edge.
- `init_ack` sampled high at edge N puts RUN in effect from edge N. The first RUN cycle updates counters at edge N+1.
- Event inputs are registered-sampled. With an event at RUN edge E, `finish` and `exit_*` are valid after edge E. Latency 1 cycle.
- With limit L and no other event, `finish` rises on the L-th RUN edge, with `cycle_cnt`=L. L=1 finishes on the first RUN edge.
- Watchdog: with W commit-free cycles from RUN entry, `finish` rises on the W-th RUN edge.
- A commit and a trap in the same cycle: the commit is counted.
- Outputs are registered; no combinational input→output paths.

## Test plan
- NUM_CORES=1, RESET_CYCLES=4: release `reset`, ack 2 cycles after `init_req` → `dut_reset` high exactly 4 cycles; `init_req` high 3 cycles; `cycle_cnt` starts at 0.
- NUM_CORES=4: commits 0b1011 for 10 cycles, then cores 1 and 3 trap simultaneously with codes 0x00/0x05 → `instr_cnt`=30 (+popcount of final cycle); cause 1, core 1, code 0x00.
- `diff_err` and `trap_valid`[0] in the same cycle → cause 3, `exit_core`=0, `exit_code`=0, `finish` sticky for 20 further cycles while counters stay frozen.
- `max_cycles`=100, commits every cycle → cause 4, `cycle_cnt`=100. Then `max_cycles`=0, no events, WDOG_CYCLES=0 → no finish after 10000 cycles.
- WDOG_CYCLES=16: commit at RUN cycle 5, then none → cause 5 at `cycle_cnt`=21. Also `instr_cnt` near 2^CYCLE_W−1 wraps to 0.
- Assert `reset` mid-RUN and mid-INIT → all outputs return to reset values immediately. The sequence restarts from HOLD, and the previous latched limit is not reused.
